// File: rtl/imem_boot_sequencer.sv
// Boot/run controller: streams host words into instruction memory, then releases the core for a cycle budget.
// Optional feature macro: IMEM_BOOT_CHECKSUM_EN (wrapping 32-bit sum of the words in the current load).
module imem_boot_sequencer #(
  parameter int unsigned ADDR_W  = 11,
  parameter int unsigned DEPTH   = 2048,
  parameter int unsigned CNT_W   = 16,
  parameter logic [31:0] PC_BASE = 32'h0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [31:0]       load_data,
  input  logic              load_last,
  input  logic              start,
  input  logic [CNT_W-1:0]  run_cycles,
  input  logic              halt,
  output logic [31:0]       imem_wdata,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [31:0]       pc_init,
  output logic              pc_set,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   word_count,
  output logic              err_overflow,
  output logic [31:0]       checksum
);

  localparam int unsigned WC_W = ADDR_W + 1;
  localparam logic [WC_W-1:0] DEPTH_C = WC_W'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_ARMED = 3'd2,
    S_RUN   = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [WC_W-1:0]   wcount_q, wcount_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  budget_q, budget_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pc_set_q, pc_set_d;
  logic              xfer;
`ifdef IMEM_BOOT_CHECKSUM_EN
  logic [31:0]       csum_q, csum_d;
`endif

  assign xfer = load_valid && ready_q;

  // Next-state and next-output logic
  always_comb begin
    state_d  = state_q;
    we_d     = 1'b0;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    wcount_d = wcount_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
    budget_d = budget_q;
`ifdef IMEM_BOOT_CHECKSUM_EN
    csum_d   = csum_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if (xfer) begin
          we_d     = 1'b1;
          waddr_d  = '0;
          wdata_d  = load_data;
          wcount_d = WC_W'(1);
`ifdef IMEM_BOOT_CHECKSUM_EN
          csum_d   = load_data;
`endif
          state_d  = load_last ? S_ARMED : S_LOAD;
        end else if (state_q == S_DONE && start) begin
          state_d  = S_RUN;
          cnt_d    = '0;
          budget_d = run_cycles;
        end
      end
      S_LOAD: begin
        if (xfer) begin
          we_d     = 1'b1;
          waddr_d  = wcount_q[ADDR_W-1:0];
          wdata_d  = load_data;
          wcount_d = wcount_q + WC_W'(1);
`ifdef IMEM_BOOT_CHECKSUM_EN
          csum_d   = csum_q + load_data;
`endif
          if (load_last) state_d = S_ARMED;
        end else if (load_valid && wcount_q >= DEPTH_C) begin
          // Word offered while imem is full: dropped, flagged until reset
          err_d = 1'b1;
          if (load_last) state_d = S_ARMED;
        end
      end
      S_ARMED: begin
        if (start) begin
          state_d  = S_RUN;
          cnt_d    = '0;
          budget_d = run_cycles;
        end
      end
      S_RUN: begin
        if (halt || (budget_q != '0 && cnt_q == budget_q - CNT_W'(1))) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    ready_d  = (state_d == S_IDLE) || (state_d == S_DONE) ||
               ((state_d == S_LOAD) && (wcount_d < DEPTH_C));
    busy_d   = (state_d == S_LOAD) || (state_d == S_RUN);
    done_d   = (state_d == S_DONE);
    pc_set_d = (state_d != S_RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      we_q     <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      wcount_q <= '0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
      budget_q <= '0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pc_set_q <= 1'b1;
`ifdef IMEM_BOOT_CHECKSUM_EN
      csum_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      wcount_q <= wcount_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
      budget_q <= budget_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pc_set_q <= pc_set_d;
`ifdef IMEM_BOOT_CHECKSUM_EN
      csum_q   <= csum_d;
`endif
    end
  end

  assign load_ready   = ready_q;
  assign imem_we      = we_q;
  assign imem_waddr   = waddr_q;
  assign imem_wdata   = wdata_q;
  assign pc_init      = PC_BASE;
  assign pc_set       = pc_set_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign word_count   = wcount_q;
  assign err_overflow = err_q;
`ifdef IMEM_BOOT_CHECKSUM_EN
  assign checksum     = csum_q;
`else
  assign checksum     = 32'h0;
`endif

endmodule

// File: tb/tb_imem_boot_sequencer.sv
// Directed bench for imem_boot_sequencer: default-depth instance plus a DEPTH=4 instance for overflow.
module tb_imem_boot_sequencer;

  logic        clk;
  logic        rst_n;
  logic        load_valid, load_last, start, halt;
  logic [31:0] load_data;
  logic [15:0] run_cycles;
  logic        load_ready, imem_we, pc_set, busy, done, err_overflow;
  logic [31:0] imem_wdata, pc_init, checksum;
  logic [10:0] imem_waddr;
  logic [11:0] word_count;

  logic        s_valid, s_last;
  logic [31:0] s_data;
  logic        s_ready, s_we, s_pc_set, s_busy, s_done, s_err;
  logic [31:0] s_wdata, s_pc_init, s_checksum;
  logic [10:0] s_waddr;
  logic [11:0] s_wcount;

  int checks   = 0;
  int failures = 0;
  int n;
  logic [31:0] exp_csum;

  imem_boot_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .load_valid(load_valid), .load_ready(load_ready), .load_data(load_data), .load_last(load_last),
    .start(start), .run_cycles(run_cycles), .halt(halt),
    .imem_wdata(imem_wdata), .imem_we(imem_we), .imem_waddr(imem_waddr),
    .pc_init(pc_init), .pc_set(pc_set), .busy(busy), .done(done),
    .word_count(word_count), .err_overflow(err_overflow), .checksum(checksum)
  );

  imem_boot_sequencer #(.DEPTH(4)) dut_small (
    .clk(clk), .rst_n(rst_n),
    .load_valid(s_valid), .load_ready(s_ready), .load_data(s_data), .load_last(s_last),
    .start(1'b0), .run_cycles(16'd0), .halt(1'b0),
    .imem_wdata(s_wdata), .imem_we(s_we), .imem_waddr(s_waddr),
    .pc_init(s_pc_init), .pc_set(s_pc_set), .busy(s_busy), .done(s_done),
    .word_count(s_wcount), .err_overflow(s_err), .checksum(s_checksum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Counts cycles pc_set stays low, bounded so a stuck RUN cannot hang the bench
  task automatic count_run(output int cnt);
    cnt = 0;
    while (pc_set === 1'b0 && cnt < 200) begin
      cnt++;
      step();
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_we"},     imem_we, 0);
    check({tag, "_waddr"},  imem_waddr, 0);
    check({tag, "_wdata"},  imem_wdata, 0);
    check({tag, "_pcinit"}, pc_init, 32'h0);
    check({tag, "_pcset"},  pc_set, 1);
    check({tag, "_ready"},  load_ready, 0);
    check({tag, "_busy"},   busy, 0);
    check({tag, "_done"},   done, 0);
    check({tag, "_wcount"}, word_count, 0);
    check({tag, "_err"},    err_overflow, 0);
    check({tag, "_csum"},   checksum, 0);
  endtask

  initial begin
    logic [31:0] prog [4];
    prog[0] = 32'h00000820; prog[1] = 32'h201d03fc; prog[2] = 32'h2010000f; prog[3] = 32'h20110009;
    rst_n = 1'b1; load_valid = 0; load_last = 0; load_data = 0; start = 0; halt = 0; run_cycles = 0;
    s_valid = 0; s_last = 0; s_data = 0;
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("rst");
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    step();
    check("idle_ready", load_ready, 1);

    // start in IDLE has no effect
    start = 1'b1;
    step();
    start = 1'b0;
    check("idle_start_busy", busy, 0);
    check("idle_start_pcset", pc_set, 1);

    // Four-word program, last on the fourth word
    load_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      load_data = prog[i];
      load_last = (i == 3);
      step();
      check($sformatf("ld_we%0d", i), imem_we, 1);
      check($sformatf("ld_addr%0d", i), imem_waddr, i);
      check($sformatf("ld_data%0d", i), imem_wdata, prog[i]);
      check($sformatf("ld_wc%0d", i), word_count, i + 1);
    end
    load_valid = 1'b0; load_last = 1'b0;
    check("armed_ready", load_ready, 0);
    check("armed_busy", busy, 0);
`ifdef IMEM_BOOT_CHECKSUM_EN
    exp_csum = 32'h603e0c34;
`else
    exp_csum = 32'h0;
`endif
    check("ld_csum", checksum, exp_csum);
    step();
    check("ld_we_drop", imem_we, 0);
    check("armed_pcset", pc_set, 1);

    // Budgeted run of 9 cycles
    run_cycles = 16'd9; start = 1'b1;
    step();
    start = 1'b0;
    check("run9_busy", busy, 1);
    count_run(n);
    check("run9_len", n, 9);
    check("run9_done", done, 1);
    check("run9_busy_end", busy, 0);

    // Unbounded run stopped by halt
    run_cycles = 16'd0; start = 1'b1;
    step();
    start = 1'b0;
    check("run0_pcset", pc_set, 0);
    check("run0_done_clr", done, 0);
    repeat (20) step();
    check("run0_still", pc_set, 0);
    halt = 1'b1;
    step();
    halt = 1'b0;
    check("halt_done", done, 1);
    check("halt_pcset", pc_set, 1);

    // Re-execute from DONE with counter cleared
    run_cycles = 16'd3; start = 1'b1;
    step();
    start = 1'b0;
    count_run(n);
    check("rerun3_len", n, 3);
    check("rerun3_done", done, 1);

    // start and load together in DONE: load wins
    start = 1'b1; load_valid = 1'b1; load_data = 32'hFFFFFFFF; load_last = 1'b0;
    step();
    start = 1'b0;
    check("lw_we", imem_we, 1);
    check("lw_addr", imem_waddr, 0);
    check("lw_wc", word_count, 1);
    check("lw_done", done, 0);
    check("lw_pcset", pc_set, 1);
    check("lw_busy", busy, 1);
    load_data = 32'h00000002; load_last = 1'b1;
    step();
    load_valid = 1'b0; load_last = 1'b0;
    check("lw2_addr", imem_waddr, 1);
    check("lw2_wc", word_count, 2);
`ifdef IMEM_BOOT_CHECKSUM_EN
    exp_csum = 32'h00000001;
`else
    exp_csum = 32'h0;
`endif
    check("csum_wrap", checksum, exp_csum);

    // One-cycle run, then abort a new load with reset
    run_cycles = 16'd1; start = 1'b1;
    step();
    start = 1'b0;
    count_run(n);
    check("run1_len", n, 1);
    load_valid = 1'b1; load_data = 32'hA5A5A5A5;
    step();
    load_data = 32'h5A5A5A5A;
    step();
    check("mid_addr", imem_waddr, 1);
    load_valid = 1'b0;
    rst_n = 1'b0;
    #1 check_reset_outputs("midrst");
    rst_n = 1'b1;
    step();
    check("post_ready", load_ready, 1);
    check("post_busy", busy, 0);
    check("post_wc", word_count, 0);

    // DEPTH=4 instance: fifth word is dropped and flagged
    s_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      s_data = 32'h100 + i;
      s_last = (i == 4);
      step();
      if (i < 4) begin
        check($sformatf("ov_we%0d", i), s_we, 1);
        check($sformatf("ov_addr%0d", i), s_waddr, i);
      end else begin
        check("ov_no5th", s_we, 0);
        check("ov_err", s_err, 1);
        check("ov_ready", s_ready, 0);
        check("ov_wc", s_wcount, 4);
      end
    end
    s_valid = 1'b0; s_last = 1'b0;
    check("ov_last_data", s_wdata, 32'h103);
    step();
    check("ov_sticky", s_err, 1);
    check("ov_armed_busy", s_busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
